// File: rtl/video_interface_sys_frame_reader.sv
// rtl/video_interface_sys_frame_reader.sv - credit-limited Avalon-MM frame reader feeding an Avalon-ST word stream.
// Optional continuous frame looping is enabled by defining FRAME_READER_LOOP_EN.
module video_interface_sys_frame_reader #(
   parameter int ADDR_W     = 15,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   input  logic              stop,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [3:0]        mem_byteenable,
   input  logic [DATA_W-1:0] mem_readdata,
   output logic [DATA_W-1:0] st_data,
   output logic              st_valid,
   input  logic              st_ready,
   output logic              st_sop,
   output logic              st_eop
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_base;
   logic [ADDR_W:0]   r_length;
   logic [ADDR_W:0]   r_issued;
   logic              r_inflight;
   logic              r_inf_sop;
   logic              r_inf_eop;
   logic              r_done;

   logic [DATA_W-1:0]     r_fifo_data [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] r_fifo_sop;
   logic [FIFO_DEPTH-1:0] r_fifo_eop;
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;

   logic w_accept;
   logic w_credit;
   logic w_issue;
   logic w_last_issue;
   logic w_push;
   logic w_pop;
   logic w_drained;
   logic w_loop_continue;

   // A read is only issued when its returning word is guaranteed a FIFO slot.
   assign w_accept     = (r_state == S_IDLE) && start;
   assign w_credit     = (r_count + CNT_W'(r_inflight)) < CNT_W'(FIFO_DEPTH);
   assign w_issue      = (r_state == S_RUN) && w_credit;
   assign w_last_issue = w_issue && ((r_issued + (ADDR_W+1)'(1)) == r_length);
   assign w_push       = r_inflight;
   assign w_pop        = st_valid && st_ready;
   assign w_drained    = !r_inflight &&
                         ((r_count == '0) || ((r_count == CNT_W'(1)) && w_pop));

`ifdef FRAME_READER_LOOP_EN
   logic r_stop_seen;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stop_seen <= 1'b0;
      end else if (w_accept) begin
         r_stop_seen <= 1'b0;
      end else if ((r_state != S_IDLE) && stop) begin
         r_stop_seen <= 1'b1;
      end
   end

   assign w_loop_continue = !(r_stop_seen || stop);
`else
   logic w_unused_stop;
   assign w_unused_stop   = stop;
   assign w_loop_continue = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_base     <= '0;
         r_length   <= '0;
         r_issued   <= '0;
         r_inflight <= 1'b0;
         r_inf_sop  <= 1'b0;
         r_inf_eop  <= 1'b0;
         r_done     <= 1'b0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
      end else begin
         r_done     <= 1'b0;
         r_inflight <= w_issue;
         r_inf_sop  <= w_issue && (r_issued == '0);
         r_inf_eop  <= w_last_issue;

         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
         else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_base   <= base_addr;
                  r_length <= length;
                  r_issued <= '0;
                  r_state  <= (length == '0) ? S_DRAIN : S_RUN;
               end
            end
            S_RUN: begin
               // Looping restarts the issue index on the last read, so frames abut.
               if (w_last_issue) begin
                  r_issued <= '0;
                  if (!w_loop_continue) r_state <= S_DRAIN;
               end else if (w_issue) begin
                  r_issued <= r_issued + (ADDR_W+1)'(1);
               end
            end
            S_DRAIN: begin
               if (w_drained) begin
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_data[r_wr_ptr] <= mem_readdata;
         r_fifo_sop[r_wr_ptr]  <= r_inf_sop;
         r_fifo_eop[r_wr_ptr]  <= r_inf_eop;
      end
   end

   assign busy           = (r_state != S_IDLE);
   assign done           = r_done;
   assign mem_address    = r_base + r_issued[ADDR_W-1:0];
   assign mem_chipselect = w_issue;
   assign mem_write      = 1'b0;
   assign mem_byteenable = 4'hF;

   // FIFO storage is not reset, so the stream outputs are gated to read 0 when empty.
   assign st_valid = (r_count != '0);
   assign st_data  = st_valid ? r_fifo_data[r_rd_ptr] : '0;
   assign st_sop   = st_valid && r_fifo_sop[r_rd_ptr];
   assign st_eop   = st_valid && r_fifo_eop[r_rd_ptr];

endmodule
